// File: rtl/snes_poll_controller.sv
// SNES gamepad poller: drives latch/clock from a tick divider, shifts in 16 bits,
// and publishes an active-high 12-button word with a one-cycle valid pulse.
module snes_poll_controller #(
    parameter int CLK_DIV     = 21,
    parameter int AUTO_POLL   = 1,
    parameter int POLL_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        poll_req,
    input  logic        serial_data,
    output logic        snes_clk,
    output logic        data_latch,
    output logic        busy,
    output logic        valid,
    output logic [11:0] buttons,
    output logic [11:0] press_events,
    output logic        pad_present,
    output logic [2:0]  dbg_state
);

    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_tick;
    logic            r_phase;
    logic [3:0]      r_bit;
    logic [15:0]     r_raw;
    logic [PW-1:0]   r_timer;

    logic            w_tick;
    logic            w_timer_hit;
    logic            w_start;
    logic            w_done_entry;
    logic            w_present;
    logic [11:0]     w_new_buttons;
    logic            w_in_poll;

    assign w_tick        = (r_tick == TW'(CLK_DIV - 1));
    assign w_timer_hit   = (r_timer == PW'(POLL_PERIOD - 1));
    assign w_start       = (r_state == IDLE) && (poll_req || ((AUTO_POLL != 0) && w_timer_hit));
    assign w_done_entry  = (r_state == HIGH) && w_tick && (r_bit == 4'd15);
    assign w_present     = &r_raw[15:12];
    assign w_new_buttons = w_present ? ~r_raw[11:0] : 12'h000;
    assign w_in_poll     = (r_state == LATCH) || (r_state == LOW) || (r_state == HIGH);
    assign dbg_state     = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = LATCH;
            LATCH:   if (w_tick && r_phase) w_next = LOW;
            LOW:     if (w_tick) w_next = HIGH;
            HIGH:    if (w_tick) w_next = (r_bit == 4'd15) ? DONE : LOW;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tick       <= '0;
            r_phase      <= 1'b0;
            r_bit        <= 4'd0;
            r_raw        <= 16'h0000;
            r_timer      <= '0;
            snes_clk     <= 1'b1;
            data_latch   <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            buttons      <= 12'h000;
            press_events <= 12'h000;
            pad_present  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_in_poll && !w_tick)
                r_tick <= r_tick + 1'b1;
            else
                r_tick <= '0;

            if (w_start)
                r_phase <= 1'b0;
            else if ((r_state == LATCH) && w_tick)
                r_phase <= ~r_phase;

            if (w_start)
                r_bit <= 4'd0;
            else if ((r_state == HIGH) && w_tick && (r_bit != 4'd15))
                r_bit <= r_bit + 4'd1;

            // Bit 0 is presented while latched; bit k follows the k-th rising edge.
            if ((r_state == LATCH) && w_tick && r_phase)
                r_raw[0] <= serial_data;
            else if ((r_state == HIGH) && w_tick && (r_bit != 4'd15))
                r_raw[r_bit + 4'd1] <= serial_data;

            if (w_start)
                r_timer <= '0;
            else if ((r_state == IDLE) && !w_timer_hit)
                r_timer <= r_timer + 1'b1;

            snes_clk   <= (w_next != LOW);
            data_latch <= (w_next == LATCH);
            busy       <= (w_next == LATCH) || (w_next == LOW) || (w_next == HIGH);
            valid      <= w_done_entry;

            if (w_done_entry) begin
                pad_present  <= w_present;
                buttons      <= w_new_buttons;
                press_events <= w_new_buttons & ~buttons;
            end
        end
    end

endmodule

// File: tb/tb_snes_poll_controller.sv
// Directed bench for snes_poll_controller with a behavioural pad model and result queue.
module tb_snes_poll_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Valid/ready note: the DUT has no backpressure; valid is a one-cycle pulse and the
  // bench must consume buttons/press_events/pad_present in that same cycle.
  logic        rst_a, rst_b, poll_req_a, poll_req_b, serial_a;
  logic        snes_clk_a, data_latch_a, busy_a, valid_a, pad_present_a;
  logic [11:0] buttons_a, press_events_a;
  logic [2:0]  state_a;
  logic        snes_clk_b, data_latch_b, busy_b, valid_b, pad_present_b;
  logic [11:0] buttons_b, press_events_b;
  logic [2:0]  state_b;

  snes_poll_controller #(.CLK_DIV(4), .AUTO_POLL(0), .POLL_PERIOD(10)) dut_a (
    .clk(clk), .reset(rst_a), .poll_req(poll_req_a), .serial_data(serial_a),
    .snes_clk(snes_clk_a), .data_latch(data_latch_a), .busy(busy_a), .valid(valid_a),
    .buttons(buttons_a), .press_events(press_events_a), .pad_present(pad_present_a),
    .dbg_state(state_a)
  );

  snes_poll_controller #(.CLK_DIV(4), .AUTO_POLL(1), .POLL_PERIOD(10)) dut_b (
    .clk(clk), .reset(rst_b), .poll_req(poll_req_b), .serial_data(1'b1),
    .snes_clk(snes_clk_b), .data_latch(data_latch_b), .busy(busy_b), .valid(valid_b),
    .buttons(buttons_b), .press_events(press_events_b), .pad_present(pad_present_b),
    .dbg_state(state_b)
  );

  // Pad model: loads on latch, shifts on snes_clk rise, active-low buttons, ID bits high.
  logic [11:0] pad_btn = 12'h000;
  logic        force_zero = 1'b0;
  logic [15:0] sh_a = 16'hffff;
  always @(posedge snes_clk_a or posedge data_latch_a) begin
    if (data_latch_a) sh_a <= {4'b1111, ~pad_btn};
    else              sh_a <= {1'b0, sh_a[15:1]};
  end
  assign serial_a = force_zero ? 1'b0 : sh_a[0];

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_poll(input logic [11:0] btn, input logic zero, input logic mid_req,
                         input logic [24:0] exp);
    int lat, falls, busy_n, n, post_lat, post_val;
    logic prev, got;
    logic [24:0] e;
    logic [11:0] held;
    lat = 0; falls = 0; busy_n = 0; n = 0; prev = 1'b1; got = 1'b0;
    pad_btn = btn;
    force_zero = zero;
    exp_q.push_back(exp);
    @(negedge clk);
    poll_req_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      poll_req_a = mid_req ? (c >= 40 && c <= 60) : 1'b0;
      if (data_latch_a) lat++;
      if (prev && !snes_clk_a) falls++;
      prev = snes_clk_a;
      if (busy_a) busy_n++;
      if (valid_a) begin
        got = 1'b1;
        n = c;
        if (mid_req) poll_req_a = 1'b1;
        if (exp_q.size() == 0) begin
          chk("queue_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pad_present", pad_present_a, e[24]);
          chk("press_events", press_events_a, e[23:12]);
          chk("buttons", buttons_a, e[11:0]);
        end
        chk("busy_in_done", busy_a, 0);
      end
    end
    chk("valid_seen", got, 1);
    chk("latency", n, 137);
    chk("latch_cycles", lat, 8);
    chk("clk_falls", falls, 16);
    chk("busy_cycles", busy_n, 136);
    held = buttons_a;
    post_lat = 0; post_val = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      poll_req_a = 1'b0;
      if (data_latch_a) post_lat++;
      if (valid_a) post_val++;
    end
    chk("post_latch", post_lat, 0);
    chk("post_valid", post_val, 0);
    chk("buttons_stable", buttons_a, held);
  endtask

  initial begin
    int falls, lat, vals;
    logic prev;
    rst_a = 1'b1; rst_b = 1'b1; poll_req_a = 1'b0; poll_req_b = 1'b0;

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_snes_clk", snes_clk_a, 1);
    chk("rst_latch", data_latch_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_buttons", buttons_a, 0);
    chk("rst_press", press_events_a, 0);
    chk("rst_present", pad_present_a, 0);
    chk("rst_state", state_a, 0);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);

    // B + A pressed
    do_poll(12'h101, 1'b0, 1'b0, {1'b1, 12'h101, 12'h101});
    // A held, UP added
    do_poll(12'h111, 1'b0, 1'b0, {1'b1, 12'h010, 12'h111});
    // Data line stuck low: no pad
    do_poll(12'h111, 1'b1, 1'b0, {1'b0, 12'h000, 12'h000});
    // poll_req mid-poll and during DONE is ignored
    do_poll(12'h101, 1'b0, 1'b1, {1'b1, 12'h101, 12'h101});

    // Reset at the fifth clock pulse aborts without publishing
    pad_btn = 12'h101;
    force_zero = 1'b0;
    @(negedge clk);
    poll_req_a = 1'b1;
    @(posedge clk);
    falls = 0; prev = 1'b1; vals = 0;
    for (int c = 0; c < 100 && falls < 5; c++) begin
      @(negedge clk);
      poll_req_a = 1'b0;
      if (prev && !snes_clk_a) falls++;
      prev = snes_clk_a;
      if (valid_a) vals++;
    end
    chk("abort_reached_pulse5", falls, 5);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort_snes_clk", snes_clk_a, 1);
    chk("abort_latch", data_latch_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_valid", valid_a, 0);
    chk("abort_buttons", buttons_a, 0);
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (valid_a || data_latch_a) vals++;
    end
    chk("abort_no_valid", vals, 0);
    do_poll(12'h101, 1'b0, 1'b0, {1'b1, 12'h101, 12'h101});

    // Auto-poll: request coincides with the timer expiry, exactly one poll starts
    @(negedge clk);
    rst_b = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("auto_idle_before", data_latch_b, 0);
    poll_req_b = 1'b1;
    @(posedge clk);
    lat = 0; vals = 0; prev = 1'b0;
    for (int c = 1; c <= 148; c++) begin
      @(negedge clk);
      poll_req_b = 1'b0;
      if (c == 1) chk("auto_start", data_latch_b, 1);
      if (c <= 145) begin
        if (data_latch_b && !prev) lat++;
        if (valid_b) vals++;
      end
      if (c == 137) chk("auto_valid_cycle", valid_b, 1);
      if (c == 137) chk("auto_buttons", buttons_b, 0);
      if (c == 137) chk("auto_present", pad_present_b, 1);
      if (c == 147) chk("auto_period_wait", data_latch_b, 0);
      if (c == 148) chk("auto_restart", data_latch_b, 1);
      prev = data_latch_b;
    end
    chk("auto_latch_pulses", lat, 1);
    chk("auto_valid_pulses", vals, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
